// File: rtl/cmd_line_sequencer_pkg.sv
// Shared definitions for the command-line sequencer.
//   - Phase indices of the 8-phase instruction cycle (PH_A1..PH_X3).
//   - Opcode (OPR) and modifier (OPA) nibbles that the sequencer decodes.
//   - is_two_word(): identifies instructions whose next word is an operand.
package cpu_defs;

    localparam logic [2:0] PH_A1 = 3'd0;
    localparam logic [2:0] PH_A2 = 3'd1;
    localparam logic [2:0] PH_A3 = 3'd2;
    localparam logic [2:0] PH_M1 = 3'd3;
    localparam logic [2:0] PH_M2 = 3'd4;
    localparam logic [2:0] PH_X1 = 3'd5;
    localparam logic [2:0] PH_X2 = 3'd6;
    localparam logic [2:0] PH_X3 = 3'd7;

    localparam logic [3:0] OPR_JCN     = 4'h1;
    localparam logic [3:0] OPR_FIM_SRC = 4'h2;
    localparam logic [3:0] OPR_JUN     = 4'h4;
    localparam logic [3:0] OPR_JMS     = 4'h5;
    localparam logic [3:0] OPR_ISZ     = 4'h7;
    localparam logic [3:0] OPR_IO      = 4'hE;
    localparam logic [3:0] OPR_ACC     = 4'hF;
    localparam logic [3:0] OPA_DCL     = 4'hD;

    // FIM and SRC share OPR=2; FIM has an even OPA and carries a data word.
    function automatic logic is_two_word(input logic [3:0] opr, input logic [3:0] opa);
        logic two;
        case (opr)
            OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: two = 1'b1;
            OPR_FIM_SRC:                        two = ~opa[0];
            default:                            two = 1'b0;
        endcase
        return two;
    endfunction

endpackage

// File: rtl/cmd_line_sequencer_if.sv
// Bus-side signals of the command-line sequencer.
//   sync      cpu -> seq  cycle marker, high for one clock at the sync phase
//   data      cpu -> seq  shared 4-bit bus, snooped only
//   acc       cpu -> seq  accumulator[2:0], sampled for DCL
//   rom_cmd   seq -> mem  ROM command strobe, active-high
//   ram_cmd_n seq -> mem  RAM bank command strobes, active-low
//   phase     seq -> cpu  current phase of the instruction cycle
interface cmd_line_if;
    logic       sync;
    logic [3:0] data;
    logic [2:0] acc;
    logic       rom_cmd;
    logic [3:0] ram_cmd_n;
    logic [2:0] phase;

    modport master (output sync, data, acc, input rom_cmd, ram_cmd_n, phase);
    modport slave  (input sync, data, acc, output rom_cmd, ram_cmd_n, phase);
endinterface

// File: rtl/cmd_line_sequencer_phase_counter.sv
// Mod-8 phase counter, realigned by sync.
//   clock, reset  system clock, async active-high reset
//   sync          cycle marker; forces the next phase to A1 and sets locked
//   phase         current phase
//   phase_next    phase of the next clock (lets the top register strobes)
//   locked        set by the first sync, cleared only by reset
//   realign       sync seen at a phase other than SYNC_PHASE
//
// phase | meaning
// 0 A1  | address nibble 1
// 1 A2  | address nibble 2
// 2 A3  | address nibble 3, command strobe
// 3 M1  | opcode OPR on data
// 4 M2  | modifier OPA on data, I/O command strobe
// 5 X1  | execute 1
// 6 X2  | execute 2, SRC command strobe
// 7 X3  | execute 3, end of cycle
module phase_counter
    import cpu_defs::*;
#(
    parameter int unsigned SYNC_PHASE = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sync,
    output logic [2:0] phase,
    output logic [2:0] phase_next,
    output logic       locked,
    output logic       realign
);

    localparam logic [2:0] SYNC_PH = SYNC_PHASE[2:0];

    logic [2:0] phase_q, phase_d;
    logic       locked_q, locked_d;

    always_comb begin
        phase_d  = phase_q + 3'd1;
        locked_d = locked_q;
        realign  = 1'b0;
        if (sync) begin
            phase_d  = PH_A1;
            locked_d = 1'b1;
            realign  = (phase_q != SYNC_PH);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_q  <= PH_A1;
            locked_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            locked_q <= locked_d;
        end
    end

    assign phase      = phase_q;
    assign phase_next = phase_d;
    assign locked     = locked_q;

endmodule

// File: rtl/cmd_line_sequencer.sv
// ROM/RAM command-line generator for the shared 4-bit bus.
// Tracks the instruction phase from sync, snoops OPR/OPA on data, holds the
// DCL bank register and drives registered rom_cmd / ram_cmd_n strobes in
// A3 (every cycle), M2 (I/O instructions) and X2 (SRC).
//   clock, reset   system clock, async active-high reset
//   bus (slave)    sync, data, acc in; rom_cmd, ram_cmd_n, phase out
module cmd_line_sequencer
    import cpu_defs::*;
#(
    parameter int unsigned SYNC_PHASE    = 7,
    parameter bit          ENABLE_IO_CMD = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    cmd_line_if.slave   bus
);

    logic [2:0] phase, phase_next;
    logic       locked, realign;

    logic [3:0] opr_q, opr_d;
    logic [3:0] opa_q, opa_d;
    logic [2:0] bank_q, bank_d;
    logic       second_word_q, second_word_d;
    logic       rom_cmd_q, rom_cmd_d;
    logic [3:0] ram_cmd_n_q, ram_cmd_n_d;
    logic       fire;

    phase_counter #(.SYNC_PHASE(SYNC_PHASE)) u_phase (
        .clock      (clock),
        .reset      (reset),
        .sync       (bus.sync),
        .phase      (phase),
        .phase_next (phase_next),
        .locked     (locked),
        .realign    (realign)
    );

    // Bank 0 selects line 0 alone; other banks use lines 3:1 as a binary code.
    function automatic logic [3:0] bank_mask(input logic [2:0] b);
        return (b == 3'd0) ? 4'b0001 : {b, 1'b0};
    endfunction

    always_comb begin
        opr_d         = opr_q;
        opa_d         = opa_q;
        bank_d        = bank_q;
        second_word_d = second_word_q;
        rom_cmd_d     = 1'b0;
        ram_cmd_n_d   = 4'hF;
        fire          = 1'b0;

        if (locked) begin
            // A second word is operand data, so it must not overwrite OPR/OPA.
            if (!second_word_q) begin
                if (phase == PH_M1) opr_d = bus.data;
                if (phase == PH_M2) opa_d = bus.data;
            end

            if (realign) begin
                second_word_d = 1'b0;
            end else if (phase == PH_X3) begin
                if (second_word_q) begin
                    second_word_d = 1'b0;
                end else begin
                    second_word_d = is_two_word(opr_q, opa_q);
                    if (opr_q == OPR_ACC && opa_q == OPA_DCL) bank_d = bus.acc;
                end
            end

            // Strobes are registered, so decide one clock ahead using phase_next.
            // A sync forces phase_next to A1, which drops any strobe of the
            // interrupted cycle. The M2 decision decodes OPR straight off data
            // during M1 because opr_q is not loaded until the end of M1.
            case (phase_next)
                PH_A3:   fire = 1'b1;
                PH_M2:   fire = ENABLE_IO_CMD && !second_word_q && (bus.data == OPR_IO);
                PH_X2:   fire = !second_word_q && (opr_q == OPR_FIM_SRC) && opa_q[0];
                default: fire = 1'b0;
            endcase

            if (fire) begin
                rom_cmd_d   = 1'b1;
                ram_cmd_n_d = ~bank_mask(bank_q);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            opr_q         <= 4'h0;
            opa_q         <= 4'h0;
            bank_q        <= 3'd0;
            second_word_q <= 1'b0;
            rom_cmd_q     <= 1'b0;
            ram_cmd_n_q   <= 4'hF;
        end else begin
            opr_q         <= opr_d;
            opa_q         <= opa_d;
            bank_q        <= bank_d;
            second_word_q <= second_word_d;
            rom_cmd_q     <= rom_cmd_d;
            ram_cmd_n_q   <= ram_cmd_n_d;
        end
    end

    assign bus.rom_cmd   = rom_cmd_q;
    assign bus.ram_cmd_n = ram_cmd_n_q;
    assign bus.phase     = phase;

endmodule

// File: tb/tb_cmd_line_sequencer.sv
// Bench for cmd_line_sequencer: two instances (I/O command enabled and
// disabled) share one stimulus stream. Expected strobes come from a
// per-instruction model (bank, second-word flag, lock) and a directed table.
module tb_cmd_line_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       sync_i;
    logic [3:0] data_i;
    logic [2:0] acc_i;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    cmd_line_if bus_a ();
    cmd_line_if bus_b ();

    assign bus_a.sync = sync_i;
    assign bus_a.data = data_i;
    assign bus_a.acc  = acc_i;
    assign bus_b.sync = sync_i;
    assign bus_b.data = data_i;
    assign bus_b.acc  = acc_i;

    cmd_line_sequencer #(.SYNC_PHASE(7), .ENABLE_IO_CMD(1'b1)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    cmd_line_sequencer #(.SYNC_PHASE(7), .ENABLE_IO_CMD(1'b0)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    typedef struct {
        logic [3:0] opr;
        logic [3:0] opa;
        logic [2:0] acc;
        logic [3:0] a3;   // ram_cmd_n expected in A3 (and in any other strobe)
        bit         m2;   // M2 strobe on the I/O-enabled instance
        bit         x2;   // X2 strobe on both instances
    } vec_t;

    // Bank-select line pattern, straight from the bank/line table.
    logic [3:0] mask_tbl [8] = '{4'h1, 4'h2, 4'h4, 4'h6, 4'h8, 4'hA, 4'hC, 4'hE};
    logic [3:0] opr_pool [10] = '{4'h0, 4'h1, 4'h2, 4'h2, 4'h4, 4'h5, 4'h7, 4'hE, 4'hF, 4'hF};

    bit         m_locked;
    logic [2:0] m_bank;
    bit         m_sw;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic model_predict(input logic [3:0] opr, input logic [3:0] opa,
                                 output bit lk, output logic [3:0] a3, output bit m2, output bit x2);
        lk = m_locked;
        a3 = ~mask_tbl[m_bank];
        m2 = (opr == 4'hE) && !m_sw;
        x2 = (opr == 4'h2) && opa[0] && !m_sw;
    endtask

    task automatic model_commit(input logic [3:0] opr, input logic [3:0] opa, input logic [2:0] acc,
                                input int last_ph, input bit do_sync);
        if (m_locked) begin
            if (last_ph != 7) begin
                m_sw = 1'b0;
            end else if (m_sw) begin
                m_sw = 1'b0;
            end else begin
                if (opr == 4'hF && opa == 4'hD) m_bank = acc;
                m_sw = (opr == 4'h1) || (opr == 4'h4) || (opr == 4'h5) || (opr == 4'h7) ||
                       (opr == 4'h2 && !opa[0]);
            end
        end
        if (do_sync) m_locked = 1'b1;
    endtask

    // Walks phases 0..last_ph starting with the DUT in phase 0 (sampled #1 after the edge).
    task automatic run_cycle(input logic [3:0] opr, input logic [3:0] opa, input logic [2:0] acc,
                             input int last_ph, input bit do_sync, input bit lk,
                             input logic [3:0] a3, input bit m2, input bit x2, input string tag);
        for (int p = 0; p <= last_ph; p++) begin
            logic       erom_a, erom_b;
            logic [3:0] eram_a, eram_b;
            erom_a = 1'b0; eram_a = 4'hF;
            erom_b = 1'b0; eram_b = 4'hF;
            if (lk) begin
                if (p == 2) begin
                    erom_a = 1'b1; eram_a = a3; erom_b = 1'b1; eram_b = a3;
                end else if (p == 4 && m2) begin
                    erom_a = 1'b1; eram_a = a3;
                end else if (p == 6 && x2) begin
                    erom_a = 1'b1; eram_a = a3; erom_b = 1'b1; eram_b = a3;
                end
                chk($sformatf("%s ph%0d phase_a", tag, p), {1'b0, bus_a.phase}, 4'(p));
                chk($sformatf("%s ph%0d phase_b", tag, p), {1'b0, bus_b.phase}, 4'(p));
            end
            chk($sformatf("%s ph%0d rom_a", tag, p), {3'b0, bus_a.rom_cmd}, {3'b0, erom_a});
            chk($sformatf("%s ph%0d ram_a", tag, p), bus_a.ram_cmd_n, eram_a);
            chk($sformatf("%s ph%0d rom_b", tag, p), {3'b0, bus_b.rom_cmd}, {3'b0, erom_b});
            chk($sformatf("%s ph%0d ram_b", tag, p), bus_b.ram_cmd_n, eram_b);
            sync_i = do_sync && (p == last_ph);
            data_i = (p == 3) ? opr : (p == 4) ? opa : 4'($urandom);
            acc_i  = (p == 7) ? acc : 3'($urandom);
            @(posedge clock);
            #1;
        end
        sync_i = 1'b0;
    endtask

    task automatic model_cycle(input logic [3:0] opr, input logic [3:0] opa, input logic [2:0] acc,
                               input int last_ph, input bit do_sync, input string tag);
        bit         lk, m2, x2;
        logic [3:0] a3;
        model_predict(opr, opa, lk, a3, m2, x2);
        run_cycle(opr, opa, acc, last_ph, do_sync, lk, a3, m2, x2, tag);
        model_commit(opr, opa, acc, last_ph, do_sync);
    endtask

    vec_t vecs [25];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{4'h0, 4'h0, 3'd0, 4'hE, 1'b0, 1'b0};  // NOP, bank 0
        vecs[1]  = '{4'hF, 4'hD, 3'd3, 4'hE, 1'b0, 1'b0};  // DCL acc=3
        vecs[2]  = '{4'h0, 4'h0, 3'd0, 4'h9, 1'b0, 1'b0};  // bank 3 visible
        vecs[3]  = '{4'hF, 4'hD, 3'd0, 4'h9, 1'b0, 1'b0};  // DCL acc=0
        vecs[4]  = '{4'h2, 4'h1, 3'd0, 4'hE, 1'b0, 1'b1};  // SRC
        vecs[5]  = '{4'h2, 4'h0, 3'd0, 4'hE, 1'b0, 1'b0};  // FIM
        vecs[6]  = '{4'h2, 4'h1, 3'd0, 4'hE, 1'b0, 1'b0};  // FIM data looks like SRC
        vecs[7]  = '{4'hE, 4'h2, 3'd0, 4'hE, 1'b1, 1'b0};  // I/O
        vecs[8]  = '{4'h4, 4'h5, 3'd0, 4'hE, 1'b0, 1'b0};  // JUN
        vecs[9]  = '{4'hE, 4'h1, 3'd0, 4'hE, 1'b0, 1'b0};  // JUN address word
        vecs[10] = '{4'hE, 4'h1, 3'd0, 4'hE, 1'b1, 1'b0};  // decoded normally again
        vecs[11] = '{4'h1, 4'h3, 3'd0, 4'hE, 1'b0, 1'b0};  // JCN
        vecs[12] = '{4'hF, 4'hD, 3'd5, 4'hE, 1'b0, 1'b0};  // JCN data looks like DCL
        vecs[13] = '{4'h0, 4'h0, 3'd0, 4'hE, 1'b0, 1'b0};  // bank still 0
        vecs[14] = '{4'hF, 4'hD, 3'd7, 4'hE, 1'b0, 1'b0};  // DCL acc=7
        vecs[15] = '{4'h0, 4'h0, 3'd0, 4'h1, 1'b0, 1'b0};  // bank 7
        vecs[16] = '{4'h2, 4'h3, 3'd0, 4'h1, 1'b0, 1'b1};  // SRC on bank 7
        vecs[17] = '{4'h7, 4'h0, 3'd0, 4'h1, 1'b0, 1'b0};  // ISZ
        vecs[18] = '{4'h2, 4'h1, 3'd0, 4'h1, 1'b0, 1'b0};  // ISZ address
        vecs[19] = '{4'h5, 4'h0, 3'd0, 4'h1, 1'b0, 1'b0};  // JMS
        vecs[20] = '{4'hF, 4'hD, 3'd2, 4'h1, 1'b0, 1'b0};  // JMS address
        vecs[21] = '{4'h0, 4'h0, 3'd0, 4'h1, 1'b0, 1'b0};
        vecs[22] = '{4'hE, 4'hD, 3'd0, 4'h1, 1'b1, 1'b0};  // I/O with OPA=D is not DCL
        vecs[23] = '{4'hF, 4'hD, 3'd1, 4'h1, 1'b0, 1'b0};  // DCL acc=1
        vecs[24] = '{4'h0, 4'h0, 3'd0, 4'hD, 1'b0, 1'b0};

        sync_i = 1'b0; data_i = 4'h0; acc_i = 3'd0;
        m_locked = 1'b0; m_bank = 3'd0; m_sw = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        chk("reset rom_a",   {3'b0, bus_a.rom_cmd}, 4'h0);
        chk("reset ram_a",   bus_a.ram_cmd_n,       4'hF);
        chk("reset phase_a", {1'b0, bus_a.phase},   4'h0);
        chk("reset ram_b",   bus_b.ram_cmd_n,       4'hF);
        reset = 1'b0;

        // Unlocked: nothing may strobe, even for I/O or SRC words.
        model_cycle(4'hE, 4'h1, 3'd0, 7, 1'b0, "nolock0");
        model_cycle(4'h2, 4'h1, 3'd4, 7, 1'b1, "nolock1");

        for (int i = 0; i < 25; i++) begin
            run_cycle(vecs[i].opr, vecs[i].opa, vecs[i].acc, 7, 1'b1, 1'b1,
                      vecs[i].a3, vecs[i].m2, vecs[i].x2, $sformatf("vec%0d", i));
            model_commit(vecs[i].opr, vecs[i].opa, vecs[i].acc, 7, 1'b1);
        end

        // Resync in the middle of a second word clears it: the next (E,1) is an I/O op.
        model_cycle(4'h4, 4'h0, 3'd0, 7, 1'b1, "jun_resync");
        model_cycle(4'hE, 4'h1, 3'd0, 4, 1'b1, "sw_cut_ph4");
        model_cycle(4'hE, 4'h1, 3'd0, 7, 1'b1, "after_cut");
        // SRC cut at M2: no X2 strobe, phase restarts at A1.
        model_cycle(4'h2, 4'h1, 3'd0, 4, 1'b1, "src_cut_ph4");
        model_cycle(4'h0, 4'h0, 3'd0, 7, 1'b1, "after_src_cut");
        // DCL cut before X3 leaves the bank alone.
        model_cycle(4'hF, 4'hD, 3'd6, 5, 1'b1, "dcl_cut_ph5");
        model_cycle(4'h0, 4'h0, 3'd0, 7, 1'b1, "after_dcl_cut");
        // Missing sync: free-run keeps decoding.
        model_cycle(4'h2, 4'h1, 3'd0, 7, 1'b0, "nosync");
        model_cycle(4'hE, 4'h3, 3'd0, 7, 1'b1, "after_nosync");

        for (int i = 0; i < 80; i++) begin
            logic [3:0]  opr, opa;
            logic [2:0]  acc;
            int unsigned kind;
            opr  = opr_pool[$urandom_range(9, 0)];
            opa  = ($urandom_range(1, 0) == 0) ? 4'hD : 4'($urandom);
            acc  = 3'($urandom);
            kind = $urandom_range(19, 0);
            if (kind == 0)
                model_cycle(opr, opa, acc, int'($urandom_range(6, 0)), 1'b1, $sformatf("rnd%0d cut", i));
            else if (kind == 1)
                model_cycle(opr, opa, acc, 7, 1'b0, $sformatf("rnd%0d nosync", i));
            else
                model_cycle(opr, opa, acc, 7, 1'b1, $sformatf("rnd%0d", i));
        end

        // Reset during an X2 strobe.
        model_cycle(4'hF, 4'hD, 3'd5, 7, 1'b1, "dcl5");
        model_cycle(4'h0, 4'h0, 3'd0, 7, 1'b1, "pre_src");
        run_cycle(4'h2, 4'h1, 3'd0, 5, 1'b0, 1'b1, 4'h5, 1'b0, 1'b1, "src_b5");
        chk("x2 rom_a before reset", {3'b0, bus_a.rom_cmd}, 4'h1);
        chk("x2 ram_a before reset", bus_a.ram_cmd_n,       4'h5);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset rom_a",   {3'b0, bus_a.rom_cmd}, 4'h0);
        chk("async reset ram_a",   bus_a.ram_cmd_n,       4'hF);
        chk("async reset ram_b",   bus_b.ram_cmd_n,       4'hF);
        chk("async reset phase_a", {1'b0, bus_a.phase},   4'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        m_locked = 1'b0; m_bank = 3'd0; m_sw = 1'b0;
        model_cycle(4'hE, 4'h1, 3'd3, 7, 1'b1, "relock");
        run_cycle(4'h0, 4'h0, 3'd0, 7, 1'b1, 1'b1, 4'hE, 1'b0, 1'b0, "bank0_after_reset");
        model_commit(4'h0, 4'h0, 3'd0, 7, 1'b1);
        model_cycle(4'hE, 4'h0, 3'd0, 7, 1'b1, "io_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
